// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq
//   Sequential BCD-to-binary converter. One x10-and-add datapath is time-shared
//   across the digits, most-significant digit first, one digit per clock.
//   A word is accepted in IDLE, converted over DIGITS clocks in CONV, and
//   held in DONE until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   bcd word presented
//   in_ready   converter can accept a word (registered)
//   bcd        packed BCD, digit0 in bits [3:0]
//   out_valid  result available
//   out_ready  consumer accepts result
//   binary     converted value truncated to BIN_W bits
//   overflow   decimal value > 2^BIN_W-1
//   err        a nibble > 9 was seen in the word (only when BCD_DIGIT_CHECK_EN
//              is defined; otherwise tied 0)
//
// Build option
//   BCD_DIGIT_CHECK_EN : enables the per-digit nibble > 9 check and err flag.
module bcd_to_binary_seq #(
  parameter int DIGITS = 5,
  parameter int BIN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      binary,
  output logic                  overflow,
  output logic                  err
);

  localparam int AW = 4*DIGITS;
  localparam int CW = $clog2(DIGITS+1);
  // Scratch width wide enough for both truncation and the overflow test.
  localparam int XW = (AW > BIN_W) ? AW : BIN_W;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   sreg, acc, acc_step;
  logic [CW-1:0]   cnt;
  logic [3:0]      nib;
  logic [XW-1:0]   acc_ext;
  logic            last, accept, handshake;

  assign nib       = sreg[AW-1 -: 4];
  // acc*10 + nib; acc never exceeds 4*DIGITS bits even with hex nibbles.
  assign acc_step  = (acc << 3) + (acc << 1) + AW'(nib);
  assign acc_ext   = XW'(acc_step);
  assign last      = (cnt == CW'(DIGITS-1));
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)           state_nxt = CONV;
      CONV:    if (last)             state_nxt = DONE;
      DONE:    if (handshake)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next state, so in_ready
  // rises on the first edge out of reset and on the handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg     <= '0;
      acc      <= '0;
      cnt      <= '0;
      binary   <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      sreg <= bcd;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == CONV) begin
      acc  <= acc_step;
      sreg <= sreg << 4;
      cnt  <= cnt + CW'(1);
      if (last) begin
        binary   <= acc_ext[BIN_W-1:0];
        overflow <= (acc_ext >> BIN_W) != '0;
      end
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic bad, err_sticky, err_q;

  assign bad = (nib > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_q      <= 1'b0;
    end else if (accept) begin
      err_sticky <= 1'b0;
    end else if (state == CONV) begin
      err_sticky <= err_sticky | bad;
      if (last) err_q <= err_sticky | bad;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// transaction-level model of the converter.
module tb_bcd_to_binary_seq;
  localparam int DIGITS = 5;
  localparam int BIN_W  = 16;
`ifdef BCD_DIGIT_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [4*DIGITS-1:0] bcd = '0;
  logic in_ready, out_valid, overflow, err;
  logic [BIN_W-1:0] binary;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .bcd(bcd), .out_valid(out_valid), .out_ready(out_ready),
    .binary(binary), .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  // Decimal value of a word, nibbles weighted by powers of ten.
  function automatic longint dec_val(input logic [4*DIGITS-1:0] w);
    longint v = 0;
    longint p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v += longint'(w[4*i +: 4]) * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic bit has_bad(input logic [4*DIGITS-1:0] w);
    for (int i = 0; i < DIGITS; i++)
      if (w[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level model: accept when ready, result appears DIGITS edges
  // later, held until taken; ready comes back on the handshake edge.
  logic                m_rdy, m_ov, m_ovf, m_err;
  logic [BIN_W-1:0]    m_bin;
  logic [4*DIGITS-1:0] m_word;
  int                  m_cd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy <= 1'b0; m_ov <= 1'b0; m_bin <= '0; m_ovf <= 1'b0; m_err <= 1'b0;
      m_cd <= 0; m_word <= '0;
    end else if (m_rdy) begin
      if (in_valid) begin
        m_word <= bcd; m_cd <= DIGITS; m_rdy <= 1'b0;
      end
    end else if (m_cd != 0) begin
      m_cd <= m_cd - 1;
      if (m_cd == 1) begin
        m_ov  <= 1'b1;
        m_bin <= BIN_W'(dec_val(m_word) % (longint'(1) << BIN_W));
        m_ovf <= dec_val(m_word) >= (longint'(1) << BIN_W);
        m_err <= ERR_EN && has_bad(m_word);
      end
    end else if (m_ov) begin
      if (out_ready) begin
        m_ov <= 1'b0; m_rdy <= 1'b1;
      end
    end else begin
      m_rdy <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checks++;
      if ({in_ready, out_valid, binary, overflow, err} !==
          {m_rdy, m_ov, m_bin, m_ovf, m_err}) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t: got rdy=%b vld=%b bin=%0d ovf=%b err=%b expected rdy=%b vld=%b bin=%0d ovf=%b err=%b",
                 $time, in_ready, out_valid, binary, overflow, err,
                 m_rdy, m_ov, m_bin, m_ovf, m_err);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) chk({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input string name);
    int lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    chk({name, "_latency"}, lat, DIGITS);
  endtask

  task automatic xfer(input string name, input logic [4*DIGITS-1:0] w,
                      input longint eb, input bit eo, input bit ee, input int hold);
    wait_ready(name);
    in_valid = 1'b1; bcd = w; out_ready = (hold == 0);
    tick();                          // accept edge
    in_valid = 1'b0; bcd = 20'($urandom);
    wait_valid(name);
    for (int k = 0; k < hold; k++) begin
      chk({name, "_hold_bin"}, binary, eb);
      chk({name, "_hold_rdy"}, {out_valid, in_ready}, 2'b10);
      tick();
    end
    out_ready = 1'b1;
    chk({name, "_bin"}, binary, eb);
    chk({name, "_ovf"}, overflow, eo);
    chk({name, "_err"}, err, ee);
    tick();                          // handshake edge
    chk({name, "_post"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    // Model pins against hand-computed values.
    chk("model_9999",  dec_val(20'h09999), 9999);
    chk("model_99999", dec_val(20'h99999) % 65536, 34463);
    chk("model_65536", dec_val(20'h65536) % 65536, 0);
    chk("model_A000",  dec_val(20'h0A000), 10000);

    tick();
    checking = 1'b1;
    tick();
    chk("reset_state", {in_ready, out_valid, binary, overflow, err}, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", in_ready, 1);

    xfer("w09999", 20'h09999, 9999, 0, 0, 0);
    xfer("w65535", 20'h65535, 65535, 0, 0, 0);
    xfer("w65536", 20'h65536, 0, 1, 0, 0);
    xfer("w99999", 20'h99999, 34463, 1, 0, 0);
    xfer("w01023_bp", 20'h01023, 1023, 0, 0, 4);
    xfer("w00000", 20'h00000, 0, 0, 0, 0);

    // in_valid held through conversion with a new word on bcd.
    wait_ready("hold_iv");
    in_valid = 1'b1; bcd = 20'h04096; out_ready = 1'b1;
    tick();
    bcd = 20'h00255;
    wait_valid("w04096");
    chk("w04096_bin", binary, 4096);
    tick();
    chk("w04096_rdy", in_ready, 1);
    tick();                          // accepts 0x00255
    in_valid = 1'b0;
    wait_valid("w00255");
    chk("w00255_bin", binary, 255);
    tick();

    // Reset during CONV step 3.
    wait_ready("rst_mid");
    in_valid = 1'b1; bcd = 20'h12345;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {in_ready, out_valid, binary, overflow, err}, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) chk("rst_mid_no_valid", out_valid, 0);
      tick();
    end
    xfer("w00010", 20'h00010, 10, 0, 0, 0);

    xfer("w0A000", 20'h0A000, 10000, 0, ERR_EN, 0);
    xfer("w00009", 20'h00009, 9, 0, 0, 0);

    // Random traffic, checked by the per-cycle compare.
    for (int i = 0; i < 800; i++) begin
      logic [4*DIGITS-1:0] w;
      for (int d = 0; d < DIGITS; d++) w[4*d +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) w[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      in_valid  = $urandom_range(0, 1);
      bcd       = w;
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) tick();

    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Sequential, handshaked BCD-to-binary converter.
- Time-shares one ×10-and-add datapath, processing one BCD digit per clock, most-significant digit first.
- Sits between a decimal entry/display front end and 16-bit binary consumers.
- Replaces the wide parallel multiplier tree with a small controller and an accumulator.

Parameters:
- DIGITS, 5, number of BCD digits per input word; bcd width = 4*DIGITS.
- BIN_W, 16, width of the binary result; larger converted values are flagged as overflow.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  bcd word presented
- in_ready  output  1  converter can accept a word
- bcd  input  4*DIGITS  packed BCD; digit0 in bits [3:0]
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- binary  output  BIN_W  converted value, truncated to BIN_W bits
- overflow  output  1  decimal value > 2^BIN_W-1
- err  output  1  a nibble > 9 was seen (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; in_ready=0, out_valid=0, binary=0, overflow=0, err=0.
  - Accumulator, digit counter and shift register all cleared.
  - in_ready is registered and rises on the first clk edge with rst_n high.
- States:
  - IDLE -> CONV on in_valid&&in_ready.
  - CONV -> DONE after DIGITS digit steps.
  - DONE -> IDLE on out_valid&&out_ready.
- IDLE:
  - in_ready=1.
  - On accept, capture bcd into the shift register; clear accumulator, counter and sticky flags; in_ready drops at that edge.
- CONV:
  - Each edge does acc = acc*10 + top nibble, shifts the register left 4, and increments the counter.
  - acc is 4*DIGITS bits wide, which cannot overflow internally since 10^DIGITS < 16^DIGITS.
- DONE:
  - Entered on the edge of the last digit step. The same edge registers binary=acc[BIN_W-1:0], overflow=(acc >= 2^BIN_W) and err.
  - out_valid=1, in_ready=0.
  - binary, overflow and err hold stable while out_valid && !out_ready.
- Latency: accept edge T0; out_valid is high from edge T0+DIGITS (DIGITS=5: 5 clocks).
- Throughput: one word per DIGITS+2 cycles minimum. in_ready returns high on the edge after the output handshake.
- Input rules:
  - in_valid is ignored outside IDLE.
  - bcd is sampled only on the accept edge; later changes have no effect.
- Output clear: out_valid clears on the handshake edge. binary, overflow and err retain their last values until the next DONE.
- No simultaneous accept and output handshake: states are exclusive.
- Reset mid-CONV or mid-DONE aborts the word; no partial result is emitted.
- All-zero input yields binary=0, overflow=0.

Optional Feature:
- Macro: BCD_DIGIT_CHECK_EN.
- Defined:
  - Each digit step tests the nibble > 9 and sets a sticky flag, cleared on accept; err reflects it in DONE.
  - The nibble is still accumulated at its hex value.
- Undefined: no check logic; err is tied 0. Port list is unchanged.

Test Plan:
- Reset, then bcd=0x09999 with in_valid pulsed, out_ready=1 -> out_valid exactly 5 clocks after accept; binary=9999, overflow=0, err=0; in_ready high one cycle after handshake.
- bcd=0x65535 -> binary=65535, overflow=0; then bcd=0x65536 -> binary=0, overflow=1; then bcd=0x99999 -> binary=34463 (0x869F), overflow=1.
- Backpressure: bcd=0x01023 with out_ready held low 4 cycles -> out_valid, binary=1023 stable throughout, in_ready=0; consumed on first out_ready=1, in_ready high next cycle.
- in_valid held high and bcd changed to 0x00255 during CONV of 0x04096 -> result 4096; 0x00255 accepted only after return to IDLE -> 255.
- rst_n low for 1 cycle at CONV step 3 of 0x12345 -> all outputs 0 immediately; no out_valid; next word 0x00010 -> 10.
- With BCD_DIGIT_CHECK_EN: bcd=0x0A000 -> binary=10000, err=1; next word 0x00009 -> err=0. Without the macro -> err=0 for both.
